// File: rtl/shift_seq_pkg.sv
// Shared types for the iterative shifter.
// Opcodes match the CPU shift encoding.
package shift_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_RSV = 2'b11
  } shift_op_t;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_SHIFT = 2'b01,
    S_DONE  = 2'b10
  } shift_state_t;

endpackage

// File: rtl/shift_seq_sl2.sv
// Shift-left-by-2 datapath element with zero fill.
// Purely combinational.
module sl2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] y
);

  assign y = {a[WIDTH-3:0], 2'b00};

endmodule

// File: rtl/shift_seq.sv
// Iterative SLL/SRL/SRA unit: up to 2 bit positions per cycle
// with a start/busy/done handshake.
import shift_pkg::*;

module shift_seq #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Y
);

  shift_state_t     state;
  shift_op_t        op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] acc_sl2;
  logic [SHW-1:0]   cnt;
  logic [SHW-1:0]   cnt_nxt;
  logic             two;
  logic             sign;

  sl2 #(.WIDTH(WIDTH)) u_sl2 (
    .a(acc),
    .y(acc_sl2)
  );

  assign two  = cnt >= SHW'(2);
  assign sign = acc[WIDTH-1];

  always_comb begin
    acc_nxt = acc;
    cnt_nxt = two ? cnt - SHW'(2) : cnt - SHW'(1);
    case (op_q)
      SH_SRL: acc_nxt = two ? {2'b00, acc[WIDTH-1:2]}
                            : {1'b0, acc[WIDTH-1:1]};
      SH_SRA: acc_nxt = two ? {{2{sign}}, acc[WIDTH-1:2]}
                            : {sign, acc[WIDTH-1:1]};
      // reserved opcode executes as SLL
      default: acc_nxt = two ? acc_sl2
                             : {acc[WIDTH-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      op_q  <= SH_SLL;
      acc   <= '0;
      cnt   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= A;
            cnt   <= shamt;
            op_q  <= shift_op_t'(op);
            state <= (shamt == '0) ? S_DONE : S_SHIFT;
          end
        end
        S_SHIFT: begin
          acc <= acc_nxt;
          cnt <= cnt_nxt;
          if (cnt_nxt == '0)
            state <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = state != S_IDLE;
  assign done = state == S_DONE;
  assign Y    = acc;

endmodule

// File: doc/shift_seq.md
# shift_seq

Multi-cycle iterative barrel-shift replacement for the CPU's shift instructions (SLL/SRL/SRA). A `WIDTH`-bit operand is shifted by a run-time amount, at most 2 bit positions per cycle:
- by 2 whenever ≥2 positions remain;
- by 1 for the final odd position.

A start/busy/done handshake lets the control unit stall the pipeline while a shift is in flight. The block sequences the existing `sl2` shift-by-2 datapath element instead of instantiating a full barrel shifter.

## Interface
- `WIDTH`, 32, operand/result width in bits.
- `SHW`, `$clog2(WIDTH)`, shift-amount width.

- `clk`  in  1  system clock; all state changes on rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  2'b00 SLL, 2'b01 SRL, 2'b10 SRA, 2'b11 reserved (executes as SLL).
- `A`  in  WIDTH  operand; captured when `start` is accepted.
- `shamt`  in  SHW  shift amount, 0..WIDTH-1; captured with `A`.
- `busy`  out  1  high whenever state ≠ IDLE.
- `done`  out  1  one-cycle pulse; `Y` is valid in this cycle.
- `Y`  out  WIDTH  result register; holds its value until the next accepted start or reset.

## Operation
States: IDLE, SHIFT, DONE.

- **IDLE**
  - When `start`=1: latch `A` into accumulator `acc`, `shamt` into counter `cnt`, and `op`.
  - Next state is DONE if `shamt`=0, otherwise SHIFT.
  - When `start`=0: remain in IDLE.
- **SHIFT**, one step per cycle:
  - If `cnt`≥2: shift `acc` by 2 and set `cnt` -= 2.
  - Otherwise: shift `acc` by 1 and set `cnt` -= 1.
  - When the updated `cnt` is 0: go to DONE.
- **DONE**
  - Assert `done`=1.
  - Go to IDLE unconditionally.
- **Shift semantics**
  - SLL and reserved: zero-fill from the LSB.
  - SRL: zero-fill from the MSB.
  - SRA: replicate `acc[WIDTH-1]` into each vacated MSB position. For a 2-step this means 2 copies of the sign bit.
- **Output**: `Y` is driven directly from `acc`. `acc` is not cleared at DONE.
- **`start` outside IDLE**: ignored, including in the DONE cycle. `A`, `shamt` and `op` are don't-care outside the accept cycle.
- **`shamt` ≥ WIDTH**: cannot occur because `shamt` is SHW bits wide. For non-power-of-2 `WIDTH`, values ≥ `WIDTH` shift the full counted amount with no saturation.
- **Reset** (`rst_n`=0 at an edge): state=IDLE, `acc`=0, `cnt`=0, `busy`=0, `done`=0, `Y`=0. This holds even mid-SHIFT: the operation is aborted and `done` is never pulsed for it.

## Timing
- Start accepted at edge k.
- `shamt`=n>0:
  - SHIFT occupies cycles k+1 … k+⌈n/2⌉.
  - `done`=1 in cycle k+⌈n/2⌉+1.
  - `busy`=1 from cycle k+1 through the done cycle inclusive.
- `shamt`=0:
  - DONE in cycle k+1.
  - `busy`=1 and `done`=1 for that single cycle.
  - `Y`=`A`.
- Worst case with `WIDTH`=32, `shamt`=31: 16 SHIFT cycles plus 1 DONE cycle = 17 cycles after accept.
- Earliest next accept is the cycle after `done`, i.e. the first IDLE cycle. Back-to-back operations therefore carry a 1-cycle IDLE bubble.
- `busy`, `done` and `Y` are all registered; there are no combinational input→output paths.

## Structure
- Package `shift_pkg` holds:
  - `shift_op_t` enum: `SH_SLL`=2'b00, `SH_SRL`=2'b01, `SH_SRA`=2'b10, `SH_RSV`=2'b11.
  - `shift_state_t` enum: `S_IDLE`, `S_SHIFT`, `S_DONE`.
- Instantiate the existing `sl2` module (`WIDTH` passed through) for the left-by-2 step.
- Right-by-2 and all by-1 steps are inline logic. No further sub-modules.

## Test plan
1. SLL, `A`=32'h0000_0001, `shamt`=5 → 3 SHIFT cycles, `done` at k+4, `Y`=32'h0000_0020, `busy` high k+1..k+4.
2. SRA, `A`=32'h8000_0000, `shamt`=31 → `done` at k+17, `Y`=32'hFFFF_FFFF. Same operands with SRL → `Y`=32'h0000_0001.
3. SRL, `A`=32'hF000_000F, `shamt`=4 → `done` at k+3, `Y`=32'h0F00_0000. SRA of the same → `Y`=32'hFF00_0000.
4. `shamt`=0, SLL, `A`=32'hDEAD_BEEF → `busy` and `done` both high only at k+1, `Y`=32'hDEAD_BEEF.
5. Start accepted, then `start`=1 held with `A`=32'h1234_5678 during SHIFT and DONE → second request ignored; result matches the first operands only. The next accept occurs at the first IDLE cycle.
6. Reset asserted at k+2 of an SLL with `shamt`=20 → next cycle `busy`=0, `done`=0, `Y`=0, and no `done` pulse afterwards.
